// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetch queue with flush/redirect and pre-split head fields.
// Optional same-cycle bypass of the memory response into an empty queue: PREFETCH_BYPASS_EN.
`timescale 1ns/1ps
module fetch_prefetch_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  input  logic                   flush,
  input  logic [XLEN-1:0]        flush_pc,
  input  logic                   deq,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [XLEN-1:0]        instr_pc,
  output logic [XLEN-1:0]        instr_pc_next,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [2:0]             func3,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [6:0]             func7,
  output logic [24:0]            imm_bits,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [PW-1:0]   head_q, head_n, tail_q, tail_n;
  logic [CW-1:0]   count_q, count_n;
  logic [XLEN-1:0] pc_q, pc_n, addr_q, addr_n;
  logic            req_q, req_n, drop_q, drop_n;
  logic            done, push, pop, bypass;
  logic            out_valid;
  entry_t          out_e;
  logic            unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc[1:0];

  // Next-state: queue occupancy, fetch pointer, drop flag and the single outstanding request
  always_comb begin
    done = req_q & mem_ready;
`ifdef PREFETCH_BYPASS_EN
    bypass = done & ~drop_q & ~flush & (count_q == '0);
`else
    bypass = 1'b0;
`endif
    push    = done & ~drop_q & ~flush & ~(bypass & deq);
    pop     = deq & (count_q != '0) & ~flush;
    count_n = count_q;
    head_n  = head_q;
    tail_n  = tail_q;
    pc_n    = pc_q;
    drop_n  = drop_q;
    req_n   = req_q;
    addr_n  = addr_q;

    if (flush) begin
      count_n = '0;
      head_n  = '0;
      tail_n  = '0;
    end else begin
      if (push) tail_n = tail_q + PW'(1);
      if (pop)  head_n = head_q + PW'(1);
      if (push && !pop)      count_n = count_q + CW'(1);
      else if (pop && !push) count_n = count_q - CW'(1);
    end

    if (flush)               pc_n = {flush_pc[XLEN-1:2], 2'b00};
    else if (done && !drop_q) pc_n = pc_q + XLEN'(4);

    // A request still waiting at a flush edge completes at its old address and is discarded
    if (done)               drop_n = 1'b0;
    else if (flush && req_q) drop_n = 1'b1;

    if (!(req_q && !mem_ready)) begin
      req_n  = (count_n < CW'(DEPTH));
      addr_n = pc_n;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      drop_q  <= drop_n;
    end
  end

  // Entry storage; contents are masked by the valid flag so no reset is needed
  always_ff @(posedge clk) begin
    if (push) q_mem[tail_q] <= {addr_q, mem_rdata};
  end

  // Head presentation
  always_comb begin
    out_valid = (count_q != '0);
    out_e     = q_mem[head_q];
`ifdef PREFETCH_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_e     = {addr_q, mem_rdata};
    end
`endif
  end

  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign count         = count_q;
  assign instr_valid   = out_valid;
  assign instr         = out_valid ? out_e.word : '0;
  assign instr_pc      = out_valid ? out_e.pc : '0;
  assign instr_pc_next = instr_pc + XLEN'(4);
  assign opcode        = instr[6:0];
  assign rd            = instr[11:7];
  assign func3         = instr[14:12];
  assign rs1           = instr[19:15];
  assign rs2           = instr[24:20];
  assign func7         = instr[31:25];
  assign imm_bits      = instr[31:7];

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed scoreboard bench for fetch_prefetch_buffer: fill, full/deq, drop on flush,
// flush+deq+ready collision, address wrap via a second instance, and mid-stream reset.
`timescale 1ns/1ps
module tb_fetch_prefetch_buffer;

  logic        clk, reset;
  logic        mem_req, mem_ready, flush, deq, instr_valid;
  logic [31:0] mem_addr, mem_rdata, flush_pc, instr, instr_pc, instr_pc_next;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3;
  logic [24:0] imm_bits;
  logic [2:0]  count;

  logic        w_req, w_deq, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_next;
  logic [6:0]  unused_w_opcode, unused_w_func7;
  logic [4:0]  unused_w_rd, unused_w_rs1, unused_w_rs2;
  logic [2:0]  unused_w_func3, unused_w_count;
  logic [24:0] unused_w_imm;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_addr, w_exp;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  assign mem_rdata = word_of(mem_addr);
  assign w_rdata   = word_of(w_addr);

  fetch_prefetch_buffer dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .flush(flush), .flush_pc(flush_pc),
    .deq(deq), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_next(instr_pc_next), .opcode(opcode), .rd(rd), .func3(func3),
    .rs1(rs1), .rs2(rs2), .func7(func7), .imm_bits(imm_bits), .count(count)
  );

  fetch_prefetch_buffer #(.RESET_PC(32'hFFFFFFF8)) dut_w (
    .clk(clk), .reset(reset), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ready(1'b1), .mem_rdata(w_rdata), .flush(1'b0), .flush_pc(32'h0),
    .deq(w_deq), .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
    .instr_pc_next(w_pc_next), .opcode(unused_w_opcode), .rd(unused_w_rd),
    .func3(unused_w_func3), .rs1(unused_w_rs1), .rs2(unused_w_rs2),
    .func7(unused_w_func7), .imm_bits(unused_w_imm), .count(unused_w_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the presented head against the oldest scoreboard entry
  task automatic chk_head(input string tag);
    logic [63:0] e;
    logic [31:0] w;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed=scoreboard-empty expected=entry", tag);
    end else begin
      e = sb[0];
      w = e[31:0];
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_pc"}, instr_pc, e[63:32]);
      chk({tag, "_instr"}, instr, w);
      chk({tag, "_pc_next"}, instr_pc_next, e[63:32] + 32'd4);
      chk({tag, "_fields"}, {opcode, rd, func3, rs1, rs2, func7},
          {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25]});
      chk({tag, "_imm"}, 32'(imm_bits), 32'(w[31:7]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no-finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; reset = 1; mem_ready = 0; flush = 0; flush_pc = '0; deq = 0; w_deq = 0;
    #1 reset = 0;
    repeat (3) step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_w_req", 32'(w_req), 32'd0);

    // Zero-wait fill until full
    reset = 1; mem_ready = 1; exp_addr = 32'h0; w_exp = 32'hFFFFFFF8;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("fill_req", 32'(mem_req), 32'd1);
      chk("fill_addr", mem_addr, exp_addr);
      chk("wrap_addr", w_addr, w_exp);
      sb.push_back({exp_addr, word_of(exp_addr)});
      exp_addr += 32'd4;
      w_exp += 32'd4;
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_instr_const", instr, 32'hA5A50000);
    chk_head("full_head");
    chk("wrap_head_pc", w_pc, 32'hFFFFFFF8);
    chk("wrap_head_instr", w_instr, 32'h5A5AFFF8);
    chk("wrap_head_next", w_pc_next, 32'hFFFFFFFC);

    // Single dequeue from full reopens fetch
    deq = 1; w_deq = 1;
    void'(sb.pop_front());
    step();
    deq = 0; w_deq = 0; mem_ready = 0;
    chk("deq_count", 32'(count), 32'd3);
    chk("deq_req", 32'(mem_req), 32'd1);
    chk("deq_addr", mem_addr, 32'h10);
    chk_head("deq_head");
    chk("wrap_fc_valid", 32'(w_valid), 32'd1);
    chk("wrap_fc_pc", w_pc, 32'hFFFFFFFC);
    chk("wrap_fc_next", w_pc_next, 32'h0);

    // Flush while the request waits: old address held, its data dropped
    step();
    chk("wait_addr", mem_addr, 32'h10);
    flush = 1; flush_pc = 32'h103;
    step();
    flush = 0; sb.delete(); exp_addr = 32'h100;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_req_held", 32'(mem_req), 32'd1);
    chk("flush_addr_held", mem_addr, 32'h10);
    deq = 1;
    step();
    deq = 0;
    chk("empty_deq_count", 32'(count), 32'd0);
    chk("drop_addr_held", mem_addr, 32'h10);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, exp_addr);
    chk("dropped_valid", 32'(instr_valid), 32'd0);
    chk("dropped_count", 32'(count), 32'd0);
    mem_ready = 1;
    sb.push_back({exp_addr, word_of(exp_addr)});
    exp_addr += 32'd4;
    step();
    mem_ready = 0;
    chk("redir_count", 32'(count), 32'd1);
    chk_head("redir_head");
    chk("redir_next_addr", mem_addr, exp_addr);

    // flush, deq and mem_ready together
    flush = 1; flush_pc = 32'h200; deq = 1; mem_ready = 1;
    step();
    flush = 0; deq = 0; mem_ready = 0; sb.delete(); exp_addr = 32'h200;
    chk("coll_count", 32'(count), 32'd0);
    chk("coll_valid", 32'(instr_valid), 32'd0);
    chk("coll_req", 32'(mem_req), 32'd1);
    chk("coll_addr", mem_addr, exp_addr);
    step();
    chk("coll_no_stale", 32'(instr_valid), 32'd0);
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({exp_addr, word_of(exp_addr)});
      exp_addr += 32'd4;
      step();
    end
    mem_ready = 0;
    chk("refill_count", 32'(count), 32'd3);
    chk("refill_addr", mem_addr, exp_addr);
    chk_head("refill_head");

    // Asynchronous reset mid-stream
    #2 reset = 0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_req", 32'(mem_req), 32'd0);
    mem_ready = 1;
    step();
    chk("inrst_count", 32'(count), 32'd0);
    reset = 1; sb.delete(); exp_addr = 32'h0;
    step();
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_w_addr", w_addr, 32'hFFFFFFF8);
`ifdef PREFETCH_BYPASS_EN
    chk("bypass_valid", 32'(instr_valid), 32'd1);
    chk("bypass_instr", instr, word_of(32'h0));
    chk("bypass_pc", instr_pc, 32'h0);
`endif
    sb.push_back({exp_addr, word_of(exp_addr)});
    step();
    mem_ready = 0;
    chk("post_rst_count", 32'(count), 32'd1);
    chk_head("post_rst_head");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Parametrised successor to the single-entry instruction register of the multicycle core.
- Fetches sequential words from instruction memory through a ready-handshake and queues up to DEPTH {pc, instruction} pairs.
- Presents the head entry with pre-split fields (opcode, rd, func3, rs1, rs2, func7, imm bits) to the controller, register file and extend unit.
- Supports flush/redirect on taken branches and jumps.

Parameters:
- XLEN, 32: PC and address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- mem_req  out  1  fetch request valid.
- mem_addr  out  XLEN  fetch word address; low 2 bits always 0.
- mem_ready  in  1  memory accepts the request and returns mem_rdata this cycle.
- mem_rdata  in  32  instruction word.
- flush  in  1  discard the queue and redirect fetch.
- flush_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- deq  in  1  consumer pops the head entry (IRWrite role).
- instr_valid  out  1  head entry present.
- instr  out  32  head instruction.
- instr_pc  out  XLEN  PC of the head instruction (OldPC role).
- instr_pc_next  out  XLEN  instr_pc + 4, modulo 2^XLEN.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- func3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- func7  out  7  instr[31:25].
- imm_bits  out  25  instr[31:7].
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc = RESET_PC; queue empty; count = 0; drop flag cleared.
  - instr_valid = 0; mem_req = 0.
  - instr, instr_pc and the field outputs read 0 while empty.
- Request issue:
  - mem_req = 1 when (count + in_flight) < DEPTH and reset = 1; mem_addr = fetch_pc.
  - Only one request is outstanding at a time.
  - Once mem_req is asserted, mem_addr stays stable until mem_ready.
- Handshake completion (mem_req & mem_ready):
  - If the drop flag is clear, push {fetch_pc, mem_rdata} at the tail.
  - fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0x0 at XLEN=32).
  - Zero-wait memory gives one fetch per cycle.
- Output latency: the pushed entry is visible on instr_valid the cycle after mem_ready.
- Dequeue:
  - deq & instr_valid: the head advances at the edge, and outputs show the next entry.
  - deq while empty is ignored.
  - Push and pop in the same cycle leave count unchanged.
- Flush:
  - Queue emptied and fetch_pc = {flush_pc[XLEN-1:2], 2'b00} at the edge.
  - A request outstanding at that edge keeps its address until mem_ready; it sets the drop flag, and its data is discarded without advancing fetch_pc.
  - A new request to flush_pc then issues in the next cycle.
  - flush and mem_ready in the same cycle: the returned word is discarded, and the next request goes to flush_pc.
  - flush has priority over deq and over push.
  - A second flush during drop: fetch_pc is retargeted; the single drop is still pending.
- Full:
  - count == DEPTH implies mem_req = 0.
  - A deq in that cycle lets mem_req rise in the following cycle.
- Pointers: head/tail are $clog2(DEPTH) bits and wrap naturally; count saturates at DEPTH by construction.
- Reset mid-operation: all state clears immediately; any in-flight response is ignored.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, the drop flag is clear, no flush is active and mem_ready=1, the response drives instr/instr_pc/fields combinationally with instr_valid=1 in the same cycle.
  - If deq is also 1, the entry is consumed and not written; otherwise it is written normally.
- Undefined: one-cycle latency as above, with no combinational path from mem_rdata to outputs.

Test Plan:
- Release reset, zero-wait memory returning word = address ^ 0xA5A50000, deq=0:
  - mem_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - count reaches 4, then mem_req=0.
  - Head instr_pc=0x0, instr=0xA5A50000.
- Full queue, deq pulsed once -> count 4->3, mem_req=1 at addr 0x10 next cycle; head instr_pc=0x4.
- Memory with 3 wait states, flush=1 with flush_pc=0x103 while the request to 0x8 is pending:
  - mem_addr stays at 0x8 until ready, and that data is dropped.
  - Next request 0x100; instr_valid=0 until the 0x100 word arrives.
- flush, deq and mem_ready all in the same cycle -> count=0 next cycle; next mem_addr=flush_pc; no stale entry appears.
- RESET_PC=0xFFFFFFF8, XLEN=32 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; instr_pc_next of the 0xFFFFFFFC entry = 0x0.
- Assert reset mid-stream with count=3 -> instr_valid=0 and count=0 asynchronously; after release the first mem_addr = RESET_PC.
  - With PREFETCH_BYPASS_EN: empty queue plus mem_ready gives same-cycle instr_valid=1.
